mem_burst_ctrl: RTL
===================

Name: mem_burst_ctrl

Overview:
Parametrised line-transfer engine between the set-associative cache and main memory. It replaces the fixed free-running 4-beat address sequencer. It performs one cache-line refill (read) or writeback (write) per request, with a configurable number of beats, a per-beat ready handshake, an optional critical-word-first wrap order and a per-beat timeout. It sits between the cache's memory-side port and the main_memory port.

Parameters:
AWIDTH, 9, address bus width
DWIDTH, 8, data bus width
BEATS, 4, words per cache line; power of two, 2..16
CWF, 0, 1 = start the burst at the requested word and wrap; 0 = start at word 0
TIMEOUT, 255, maximum wait cycles per beat before abort; 0 disables the timeout

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  cache requests a line transfer
req_write  in  1  1 = writeback, 0 = refill; sampled at accept
req_addr  in  AWIDTH  any word address inside the line; sampled at accept
req_ready  out  1  engine idle and able to accept a request
wb_beat  out  BW  word offset of the current writeback beat; BW = clog2(BEATS)
wb_data  in  DWIDTH  writeback word from the cache, driven combinationally for wb_beat
fill_valid  out  1  one-cycle pulse per refill word returned
fill_beat  out  BW  word offset of fill_data
fill_data  out  DWIDTH  refill word
done  out  1  one-cycle pulse when a transfer completes
error  out  1  one-cycle pulse when a transfer aborts on timeout
mem_rd  out  1  read strobe to memory
mem_wr  out  1  write strobe to memory
mem_addr  out  AWIDTH  memory word address
mem_wdata  out  DWIDTH  memory write data
mem_rdata  in  DWIDTH  memory read data
mem_ready  in  1  memory completes the current beat

Behaviour:
- Reset (asynchronous): state IDLE, req_ready=1, and all of the following are 0: mem_rd, mem_wr, mem_addr, fill_valid, fill_beat, fill_data, done, error, and the beat and wait counters.
- Reset asserted mid-burst: the strobes drop immediately. No done or error pulse is produced.
- FSM states: IDLE, XFER.
- IDLE -> XFER when req_valid and req_ready are both high (the accept cycle T).
  - Latch line base = req_addr with the low BW bits cleared.
  - Latch start offset = req_addr[BW-1:0] if CWF=1, else 0.
  - Latch req_write.
- req_ready is 1 only in IDLE. req_valid is ignored in XFER.
- XFER behaviour:
  - mem_rd = !write and mem_wr = write, both asserted from cycle T+1.
  - mem_addr = base | offset, where offset = (start + beat_cnt) mod BEATS.
  - wb_beat = offset. mem_wdata = wb_data (combinational pass-through).
- A beat completes on a cycle where a strobe is high and mem_ready=1.
  - On completion: increment beat_cnt and clear the wait counter.
  - The strobe stays high and the address advances to the next beat with no idle cycle.
  - mem_ready while no strobe is high is ignored.
- Refill capture: on each completion, register fill_data = mem_rdata and fill_beat = offset. fill_valid=1 in the following cycle.
- Completion of the last beat (beat_cnt == BEATS-1):
  - The strobes drop in the next cycle and the FSM returns to IDLE.
  - done=1 in the next cycle, coinciding with the last fill_valid on a refill and with req_ready=1, so a back-to-back accept in that cycle is legal.
- Timeout: the wait counter increments on each strobe cycle without mem_ready.
  - If it reaches TIMEOUT (TIMEOUT != 0), the FSM goes to IDLE and the strobes drop next cycle.
  - error=1 for one cycle and done stays 0. No further fill_valid pulses occur.
- Zero-wait latency: accept at T, beats at T+1..T+BEATS, done at T+BEATS+1.
- Offset arithmetic wraps modulo BEATS. The base address never carries into the upper bits.
- mem_rd and mem_wr are never high together.

Decomposition:
- Package mem_burst_pkg:
  - state enum (IDLE, XFER)
  - function beat_w(BEATS) returning clog2
  - xfer_e enum (REFILL, WRITEBACK)
- Sub-module burst_addr_gen holds the beat counter, start offset and wrap arithmetic.
  - Inputs: load, start, advance.
  - Outputs: offset, last.

Test Plan:
- Refill, BEATS=4, CWF=0, req_addr=0x013, mem_ready tied 1, memory word = address LSBs -> mem_addr 0x010, 0x011, 0x012, 0x013 in cycles T+1..T+4; fill_data 0x10..0x13 with fill_beat 0..3; done at T+5.
- Refill, CWF=1, req_addr=0x016 -> mem_addr 0x016, 0x017, 0x014, 0x015; fill_beat 2, 3, 0, 1.
- Writeback, wb_data = 0xA0 + wb_beat, mem_ready high every third cycle -> memory receives 0xA0..0xA3 at 0x020..0x023, each address held until ready; mem_rd never asserted; done once.
- TIMEOUT=8, mem_ready held 0 -> error pulse at T+10; mem_wr/mem_rd drop; no done; req_ready=1; a new request is accepted afterwards.
- reset_n pulsed low after 2 beats of a refill -> strobes low in the same cycle; no done or error; the next request starts cleanly at beat 0.
- Back-to-back: second req_valid held high through the first transfer -> accepted in the done cycle; second burst strobes begin the next cycle.

Source files
------------

// File: rtl/mem_burst_pkg.sv
// Shared types and helpers for the cache line-transfer engine.
package mem_burst_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  typedef enum logic {
    REFILL    = 1'b0,
    WRITEBACK = 1'b1
  } xfer_e;

  function automatic int beat_w(input int beats);
    return (beats < 2) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Beat counter and wrapped word offset within a cache line.
module burst_addr_gen
  import mem_burst_pkg::*;
#(
  parameter  int BEATS = 4,
  localparam int BW    = beat_w(BEATS)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic [BW-1:0] start,
  input  logic          advance,
  output logic [BW-1:0] offset,
  output logic          last
);

  logic [BW-1:0] start_q;
  logic [BW-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      start_q <= start;
      cnt_q   <= '0;
    end else if (advance) begin
      cnt_q <= cnt_q + BW'(1);
    end
  end

  // BEATS is a power of two, so the BW-bit sum wraps modulo BEATS for free.
  assign offset = start_q + cnt_q;
  assign last   = (cnt_q == BW'(BEATS - 1));

endmodule

// File: rtl/mem_burst_ctrl.sv
// Cache line refill/writeback engine: per-beat ready handshake, optional
// critical-word-first wrap order and per-beat timeout.
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter  int AWIDTH  = 9,
  parameter  int DWIDTH  = 8,
  parameter  int BEATS   = 4,
  parameter  int CWF     = 0,
  parameter  int TIMEOUT = 255,
  localparam int BW      = beat_w(BEATS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  output logic              req_ready,
  output logic [BW-1:0]     wb_beat,
  input  logic [DWIDTH-1:0] wb_data,
  output logic              fill_valid,
  output logic [BW-1:0]     fill_beat,
  output logic [DWIDTH-1:0] fill_data,
  output logic              done,
  output logic              error,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int WW = $clog2(TIMEOUT + 2);

  state_e               state_q, state_d;
  xfer_e                xfer_q;
  logic [AWIDTH-BW-1:0] base_q;
  logic [WW-1:0]        wait_q;
  logic                 fill_valid_q, done_q, error_q;
  logic [BW-1:0]        fill_beat_q;
  logic [DWIDTH-1:0]    fill_data_q;

  logic          active, accept, complete, timed_out, last;
  logic [BW-1:0] offset, start;

  assign active    = (state_q == XFER);
  assign accept    = (state_q == IDLE) && req_valid;
  assign complete  = active && mem_ready;
  // A beat that completes on the limit cycle wins over the abort.
  assign timed_out = (TIMEOUT != 0) && active && !mem_ready && (wait_q == WW'(TIMEOUT));
  assign start     = (CWF != 0) ? req_addr[BW-1:0] : '0;

  burst_addr_gen #(.BEATS(BEATS)) u_addr_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept),
    .start   (start),
    .advance (complete),
    .offset  (offset),
    .last    (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = XFER;
      XFER:    if ((complete && last) || timed_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      xfer_q       <= REFILL;
      base_q       <= '0;
      wait_q       <= '0;
      fill_valid_q <= 1'b0;
      fill_beat_q  <= '0;
      fill_data_q  <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= complete && last;
      error_q      <= timed_out;
      fill_valid_q <= complete && (xfer_q == REFILL);
      if (accept) begin
        xfer_q <= req_write ? WRITEBACK : REFILL;
        base_q <= req_addr[AWIDTH-1:BW];
      end
      if (complete) begin
        fill_data_q <= mem_rdata;
        fill_beat_q <= offset;
      end
      if (accept || complete) wait_q <= '0;
      else if (active)        wait_q <= wait_q + WW'(1);
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign mem_rd     = active && (xfer_q == REFILL);
  assign mem_wr     = active && (xfer_q == WRITEBACK);
  assign mem_addr   = active ? {base_q, offset} : '0;
  assign mem_wdata  = wb_data;
  assign wb_beat    = offset;
  assign req_ready  = (state_q == IDLE);
  assign fill_valid = fill_valid_q;
  assign fill_beat  = fill_beat_q;
  assign fill_data  = fill_data_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
